udma_stream_packer: RTL and testbench

- Sits directly downstream of the uDMA stream unit and consumes its out_stream interface: data, datasize, valid, sot, eot and ready.
- Packs the incoming byte, halfword and word items into full 32-bit little-endian words for a word-oriented peripheral consumer.
- At end-of-transfer it flushes a final partial word, qualified by byte enables.
- Forwards sot/eot framing onto word boundaries and flags illegal input in a sticky error bit.

---
 rtl/udma_stream_packer.sv | 122 ++++++++++++
 tb/tb_udma_stream_packer.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/udma_stream_packer.sv
// udma_stream_packer: packs byte/halfword/word stream items into 32-bit
// little-endian words, flushes a byte-enabled partial word at end of
// transfer, aligns sot/eot framing to words and keeps a sticky error flag.
module udma_stream_packer #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cmd_clr_i,
  input  logic [DATA_WIDTH-1:0] in_stream_data_i,
  input  logic [1:0]            in_stream_datasize_i,
  input  logic                  in_stream_valid_i,
  input  logic                  in_stream_sot_i,
  input  logic                  in_stream_eot_i,
  output logic                  in_stream_ready_o,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic [3:0]            out_be_o,
  output logic                  out_valid_o,
  output logic                  out_sot_o,
  output logic                  out_eot_o,
  input  logic                  out_ready_i,
  output logic                  err_o
);

  // Lane arithmetic below assumes exactly four byte lanes per word.
  if (DATA_WIDTH != 32) begin : g_width_check
    $error("udma_stream_packer: only DATA_WIDTH = 32 is supported");
  end

  logic [63:0] buf_q, buf_d, buf_placed;
  logic [3:0]  cnt_q, cnt_d;
  logic        flush_q, flush_d;
  logic        sot_pend_q, sot_pend_d;
  logic        err_q, err_d;

  logic [2:0]  item_size;
  logic [3:0]  take;
  logic        accept;
  logic        fire;
  logic        word_valid;
  logic        illegal_size;

  // Item size in bytes; the reserved encoding carries no payload.
  always_comb begin
    item_size = 3'd0;
    case (in_stream_datasize_i)
      2'b00:   item_size = 3'd1;
      2'b01:   item_size = 3'd2;
      2'b10:   item_size = 3'd4;
      default: item_size = 3'd0;
    endcase
  end

  assign illegal_size      = (in_stream_datasize_i == 2'b11);
  assign in_stream_ready_o = !cmd_clr_i && !flush_q && (cnt_q <= 4'd4);
  assign accept            = in_stream_valid_i && in_stream_ready_o;
  assign word_valid        = (cnt_q >= 4'd4) || (flush_q && (cnt_q != 4'd0));
  assign fire              = word_valid && out_ready_i;
  assign take              = (cnt_q >= 4'd4) ? 4'd4 : cnt_q;

  // Each buffer lane picks up item byte (lane - cnt) when it falls inside
  // the accepted item; all other lanes keep their current contents.
  genvar gi;
  for (gi = 0; gi < 8; gi++) begin : g_lane
    logic [3:0] rel;
    logic       hit;
    assign rel = 4'(gi) - cnt_q;
    assign hit = accept && (4'(gi) >= cnt_q) && (rel < {1'b0, item_size});
    assign buf_placed[gi*8 +: 8] = hit ? in_stream_data_i[{rel[1:0], 3'b000} +: 8]
                                       : buf_q[gi*8 +: 8];
  end

  // Next-state: placement first, then the word shift-out of a fire.
  always_comb begin
    buf_d      = fire ? {32'd0, buf_placed[63:32]} : buf_placed;
    cnt_d      = cnt_q - (fire ? take : 4'd0) + (accept ? {1'b0, item_size} : 4'd0);
    sot_pend_d = sot_pend_q;
    if (accept && in_stream_sot_i && (cnt_q == 4'd0)) begin
      sot_pend_d = 1'b1;
    end else if (fire) begin
      sot_pend_d = 1'b0;
    end
    flush_d = flush_q;
    if (accept && in_stream_eot_i) begin
      flush_d = 1'b1;
    end else if (flush_q && (cnt_d == 4'd0)) begin
      flush_d = 1'b0;
    end
    err_d = err_q || (accept && (illegal_size || (in_stream_sot_i && (cnt_q != 4'd0))));
  end

  // State registers; clear has priority over normal updates.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      buf_q      <= '0;
      cnt_q      <= '0;
      flush_q    <= 1'b0;
      sot_pend_q <= 1'b0;
      err_q      <= 1'b0;
    end else if (cmd_clr_i) begin
      buf_q      <= '0;
      cnt_q      <= '0;
      flush_q    <= 1'b0;
      sot_pend_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      buf_q      <= buf_d;
      cnt_q      <= cnt_d;
      flush_q    <= flush_d;
      sot_pend_q <= sot_pend_d;
      err_q      <= err_d;
    end
  end

  assign out_valid_o = word_valid;
  assign out_data_o  = buf_q[31:0];
  assign out_be_o    = (cnt_q >= 4'd4) ? 4'hF : ((4'd1 << cnt_q[1:0]) - 4'd1);
  assign out_sot_o   = sot_pend_q;
  assign out_eot_o   = flush_q && (cnt_q <= 4'd4);
  assign err_o       = err_q;

endmodule

// File: tb/tb_udma_stream_packer.sv
// Scoreboard bench for udma_stream_packer: a byte-queue model predicts the
// packed words; a monitor pops and compares every word the DUT hands over.
module tb_udma_stream_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_clr;
  logic [31:0] in_data;
  logic [1:0]  in_ds;
  logic        in_valid, in_sot, in_eot, in_ready;
  logic [31:0] out_data;
  logic [3:0]  out_be;
  logic        out_valid, out_sot, out_eot, out_ready, err;

  always #5 clk = ~clk;

  udma_stream_packer #(.DATA_WIDTH(32)) dut (
    .clk_i(clk), .rst_i(rst), .cmd_clr_i(cmd_clr),
    .in_stream_data_i(in_data), .in_stream_datasize_i(in_ds),
    .in_stream_valid_i(in_valid), .in_stream_sot_i(in_sot),
    .in_stream_eot_i(in_eot), .in_stream_ready_o(in_ready),
    .out_data_o(out_data), .out_be_o(out_be), .out_valid_o(out_valid),
    .out_sot_o(out_sot), .out_eot_o(out_eot), .out_ready_i(out_ready),
    .err_o(err)
  );

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  be;
    logic        sot;
    logic        eot;
  } word_t;

  word_t      exp_q[$];
  logic [7:0] bq[$];
  bit         m_sot = 0;
  bit         exp_err = 0;
  int         ready_mode = 0;  // 0: always ready, 1: random, 2: stalled
  bit         mon_en = 0;
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference model: bytes of a transfer are appended in order; every 4
  // bytes form a word; the transfer's last byte closes the final word.
  task automatic model_push(input logic [31:0] d, input logic [1:0] ds, input bit sot, input bit eot);
    int    size;
    word_t w;
    size = (ds == 2'd0) ? 1 : (ds == 2'd1) ? 2 : (ds == 2'd2) ? 4 : 0;
    if (ds == 2'd3) exp_err = 1;
    if (sot) begin
      if (bq.size() == 0) m_sot = 1;
      else exp_err = 1;
    end
    for (int i = 0; i < size; i++) bq.push_back(d[8*i +: 8]);
    while (bq.size() >= 4) begin
      w.data = {bq[3], bq[2], bq[1], bq[0]};
      w.be   = 4'hF;
      w.sot  = m_sot;
      w.eot  = eot && (bq.size() == 4);
      for (int i = 0; i < 4; i++) void'(bq.pop_front());
      m_sot = 0;
      exp_q.push_back(w);
    end
    if (eot && (bq.size() > 0)) begin
      w.data = 32'd0;
      for (int i = 0; i < bq.size(); i++) w.data[8*i +: 8] = bq[i];
      w.be  = 4'hF >> (4 - bq.size());
      w.sot = m_sot;
      w.eot = 1'b1;
      m_sot = 0;
      bq.delete();
      exp_q.push_back(w);
    end
  endtask

  // Called just after a falling edge; returns on the falling edge after accept.
  task automatic send(input logic [31:0] d, input logic [1:0] ds, input bit sot, input bit eot);
    bit acc = 0;
    int n = 0;
    in_valid = 1; in_data = d; in_ds = ds; in_sot = sot; in_eot = eot;
    while (!acc && n < 200) begin
      #4;
      acc = in_ready;
      if (acc) begin
        model_push(d, ds, sot, eot);
        $display("item   data=%08h ds=%0d sot=%0b eot=%0b", d, ds, sot, eot);
      end
      @(negedge clk);
      n++;
    end
    if (!acc) chk("send_timeout", 64'(n), 64'd0);
    in_valid = 0; in_sot = 0; in_eot = 0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending_words", 64'(exp_q.size()), 64'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic do_clear();
    cmd_clr = 1;
    #4 chk("clr_ready_low", 64'(in_ready), 64'd0);
    @(negedge clk);
    cmd_clr = 0;
    bq.delete(); exp_q.delete(); m_sot = 0; exp_err = 0;
    #4;
    chk("clr_valid", 64'(out_valid), 64'd0);
    chk("clr_err", 64'(err), 64'd0);
    chk("clr_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
  endtask

  // Consumer-side ready pattern.
  initial begin
    out_ready = 1;
    forever begin
      @(negedge clk);
      case (ready_mode)
        0:       out_ready = 1;
        1:       out_ready = ($urandom_range(3) != 0);
        default: out_ready = 0;
      endcase
    end
  end

  // Monitor: compares each handed-over word and checks stall stability.
  initial begin
    bit    prev_stall = 0;
    word_t prev_word;
    word_t e;
    forever begin
      @(negedge clk);
      #4;
      if (mon_en) begin
        if (prev_stall)
          chk("stall_hold", {26'd0, out_valid, out_data, out_be, out_sot, out_eot},
              {26'd0, 1'b1, prev_word});
        if (out_valid && out_ready && !cmd_clr) begin
          $display("word   data=%08h be=%h sot=%0b eot=%0b", out_data, out_be, out_sot, out_eot);
          if (exp_q.size() == 0) begin
            chk("unexpected_word", {32'd0, out_data}, 64'hFFFF_FFFF_FFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            chk("word_data", {32'd0, out_data}, {32'd0, e.data});
            chk("word_be", 64'(out_be), 64'(e.be));
            chk("word_sot", 64'(out_sot), 64'(e.sot));
            chk("word_eot", 64'(out_eot), 64'(e.eot));
          end
        end
        prev_stall = out_valid && !out_ready && !cmd_clr;
        prev_word  = {out_data, out_be, out_sot, out_eot};
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1; cmd_clr = 0; in_valid = 0; in_data = 0; in_ds = 0; in_sot = 0; in_eot = 0;
    repeat (3) @(negedge clk);
    rst = 0;
    #4;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_data", {32'd0, out_data}, 64'd0);
    chk("rst_be", 64'(out_be), 64'd0);
    chk("rst_sot", 64'(out_sot), 64'd0);
    chk("rst_eot", 64'(out_eot), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd1);
    mon_en = 1;
    @(negedge clk);

    // Four bytes into one word, registered one cycle after the last accept.
    send(32'h11, 2'd0, 1, 0);
    send(32'h22, 2'd0, 0, 0);
    send(32'h33, 2'd0, 0, 0);
    #4 chk("t1_valid_before", 64'(out_valid), 64'd0);
    @(negedge clk);
    send(32'h44, 2'd0, 0, 0);
    #4 chk("t1_valid_after", 64'(out_valid), 64'd1);
    chk("t1_data", {32'd0, out_data}, 64'h4433_2211);
    @(negedge clk);
    drain();

    // Byte then eot word: two output words, input blocked during flush.
    send(32'hAA, 2'd0, 1, 0);
    send(32'h44332211, 2'd2, 0, 1);
    #4 chk("t2_ready_flush0", 64'(in_ready), 64'd0);
    @(negedge clk);
    #4 chk("t2_ready_flush1", 64'(in_ready), 64'd0);
    chk("t2_eot_final", 64'(out_eot), 64'd1);
    @(negedge clk);
    #4 chk("t2_ready_after", 64'(in_ready), 64'd1);
    @(negedge clk);
    drain();

    // Halfwords against a stalled consumer.
    ready_mode = 2;
    repeat (2) @(negedge clk);
    send(32'hBBAA, 2'd1, 0, 0);
    send(32'hDDCC, 2'd1, 0, 0);
    send(32'hFFEE, 2'd1, 0, 0);
    #4 chk("t3_ready_full", 64'(in_ready), 64'd0);
    for (int i = 0; i < 3; i++) begin
      chk("t3_stall_data", {32'd0, out_data}, 64'hDDCC_BBAA);
      @(negedge clk);
      #4;
    end
    @(negedge clk);
    ready_mode = 0;
    send(32'h2211, 2'd1, 0, 1);
    drain();

    // Illegal datasize: consumed, error, no bytes added.
    send(32'h5A, 2'd0, 1, 0);
    #4 chk("t4_err_before", 64'(err), 64'd0);
    @(negedge clk);
    send(32'hDEADBEEF, 2'd3, 0, 0);
    #4;
    chk("t4_err", 64'(err), 64'(exp_err));
    chk("t4_valid", 64'(out_valid), 64'd0);
    chk("t4_be_cnt", 64'(out_be), 64'h1);
    @(negedge clk);
    send(32'h01, 2'd0, 0, 0);
    send(32'h02, 2'd0, 0, 0);
    send(32'h03, 2'd0, 0, 1);
    drain();
    do_clear();

    // sot while bytes are held: error, flag from the first item only.
    send(32'h10, 2'd0, 1, 0);
    send(32'h3020, 2'd1, 1, 0);
    #4 chk("t5_err", 64'(err), 64'(exp_err));
    @(negedge clk);
    send(32'h40, 2'd0, 0, 1);
    drain();
    do_clear();

    // Clear mid-transfer, then a fresh transfer packs from lane 0.
    send(32'h01, 2'd0, 1, 0);
    send(32'h02, 2'd0, 0, 0);
    send(32'h03, 2'd0, 0, 0);
    #4 chk("t6_valid_partial", 64'(out_valid), 64'd0);
    @(negedge clk);
    do_clear();
    send(32'hA1, 2'd0, 1, 0);
    send(32'hA2, 2'd0, 0, 0);
    send(32'hA3, 2'd0, 0, 0);
    send(32'hA4, 2'd0, 0, 1);
    drain();

    // Randomized transfers with a random consumer.
    ready_mode = 1;
    for (int t = 0; t < 60; t++) begin
      int n;
      n = $urandom_range(6, 1);
      for (int i = 0; i < n; i++) begin
        logic [1:0] ds;
        bit         s;
        ds = ($urandom_range(15) == 0 && i != n - 1) ? 2'd3 : 2'($urandom_range(2));
        s  = (i == 0) && ($urandom_range(3) != 0);
        send($urandom, ds, s, i == n - 1);
        if ($urandom_range(3) == 0) @(negedge clk);
      end
    end
    drain();
    ready_mode = 0;
    #4;
    chk("rand_err", 64'(err), 64'(exp_err));
    chk("final_valid", 64'(out_valid), 64'd0);
    chk("final_ready", 64'(in_ready), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
